blit_combine_buf: RTL and testbench

BLIT_COMBINE_BUF -- requirements
Module: blit_combine_buf

---
 rtl/blit_pkg.sv | 15 +
 rtl/blit_wfifo.sv | 45 ++++
 rtl/blit_combine_buf.sv | 93 +++++++++
 tb/tb_blit_combine_buf.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// blit_pkg: pixel size encodings and parameter legality helpers shared by the combine buffer.
package blit_pkg;

   typedef enum logic [1:0] {
      SZ_8   = 2'd0,
      SZ_16  = 2'd1,
      SZ_32  = 2'd2,
      SZ_RSV = 2'd3
   } blit_size_e;

   function automatic bit word_bytes_ok(input int wb);
      return wb == 4 || wb == 8;
   endfunction

endpackage

// File: rtl/blit_wfifo.sv
// blit_wfifo: first-word fall-through FIFO holding combined words; any DEPTH, not only powers of two.
module blit_wfifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr, rptr;
   logic [CW-1:0]    count;
   logic             do_push, do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
         if (do_pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/blit_combine_buf.sv
// blit_combine_buf: merges narrow pixel writes into one pending byte-enabled word and
// queues evicted words in an FWFT FIFO for the memory-side consumer.
module blit_combine_buf
   import blit_pkg::*;
#(
   parameter int ADDR_BITS  = 26,
   parameter int WORD_BYTES = 4,
   parameter int DEPTH      = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_BITS-1:0]    in_addr,
   input  logic [31:0]             in_data,
   input  logic [1:0]              in_size,
   input  logic                    in_last,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDR_BITS-1:0]    out_addr,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic [WORD_BYTES-1:0]   out_byte_en,
   output logic                    busy
);
   localparam int LB = $clog2(WORD_BYTES);
   localparam int DW = 8 * WORD_BYTES;
   localparam int EW = ADDR_BITS + DW + WORD_BYTES;

   if (!word_bytes_ok(WORD_BYTES) || DEPTH < 2 || DEPTH > 16) begin : g_bad_param
      $error("blit_combine_buf: WORD_BYTES must be 4 or 8 and DEPTH 2..16");
   end

   logic [ADDR_BITS-1:0]  pend_addr, baddr, q_addr;
   logic [DW-1:0]         pend_data, nxt_data, bdata, q_data;
   logic [WORD_BYTES-1:0] pend_be, base_be, bmask, q_be;
   logic [LB-1:0]         off;
   logic [EW-1:0]         q_word;
   logic                  flush_pend, flag_nxt, accept, evict, full, empty;

   always_comb begin
      off      = in_addr[LB-1:0] & ~LB'(in_size == SZ_16 ? 1 : in_size == SZ_32 ? 3 : 0);
      bmask    = WORD_BYTES'(in_size == SZ_16 ? 3 : in_size == SZ_32 ? 15 : 1) << off;
      bdata    = DW'(in_data) << {off, 3'b000};
      baddr    = {in_addr[ADDR_BITS-1:LB], LB'(0)};
      accept   = in_valid && !full;
      // Every eviction reason collapses to one push; the beat always lands in a cleared register.
      evict    = !full && |pend_be && ((accept && baddr != pend_addr) || &pend_be || flush_pend);
      base_be  = evict ? '0 : pend_be;
      nxt_data = pend_data;
      for (int i = 0; i < WORD_BYTES; i++)
         nxt_data[8*i +: 8] = bmask[i] ? bdata[8*i +: 8] : pend_data[8*i +: 8];
      flag_nxt = (flush_pend && !evict && |pend_be) || flush || (accept && in_last);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_be    <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (accept) pend_be <= base_be | bmask;
         else if (evict) pend_be <= '0;
         flush_pend <= flag_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         pend_addr <= baddr;
         pend_data <= nxt_data;
      end
   end

   blit_wfifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (evict),
      .wdata ({pend_addr, pend_data, pend_be}),
      .pop   (out_valid && out_ready),
      .rdata (q_word),
      .full  (full),
      .empty (empty)
   );

   assign {q_addr, q_data, q_be} = q_word;
   assign in_ready    = !full;
   assign out_valid   = !empty;
   assign out_addr    = q_addr;
   assign out_data    = q_data;
   assign out_byte_en = out_valid ? q_be : '0;
   assign busy        = |pend_be || !empty || flush_pend;

endmodule

// File: tb/tb_blit_combine_buf.sv
// tb_blit_combine_buf: directed vector table, corner sequences and a randomized
// transaction-level scoreboard for the write-combining buffer.
module tb_blit_combine_buf;

   typedef struct {
      logic [25:0] a;
      logic [31:0] d;
      logic [3:0]  b;
   } word_t;

   typedef struct {
      logic [25:0] a;
      logic [31:0] d;
      logic [1:0]  s;
      logic [25:0] ea;
      logic [31:0] ed;
      logic [3:0]  eb;
   } vec_t;

   logic        clock, reset;
   logic        in_valid, in_ready, in_last, flush, out_valid, out_ready, busy;
   logic [25:0] in_addr, out_addr;
   logic [31:0] in_data, out_data;
   logic [1:0]  in_size;
   logic [3:0]  out_byte_en;

   logic        w8_in_valid, w8_in_ready, w8_in_last, w8_flush, w8_out_valid, w8_out_ready, w8_busy;
   logic [25:0] w8_in_addr, w8_out_addr;
   logic [31:0] w8_in_data;
   logic [1:0]  w8_in_size;
   logic [63:0] w8_out_data;
   logic [7:0]  w8_out_byte_en;

   logic        dir_ready, rnd_ready;
   bit          rand_on, model_on;
   int          tests, fails;

   word_t       got_q[$], exp_q[$];
   logic [25:0] got8_a[$];
   logic [63:0] got8_d[$];
   logic [7:0]  got8_b[$];

   logic [25:0] mp_addr;
   logic [7:0]  mp_b [4];
   logic [3:0]  mp_m;
   bit          mp_f;

   assign out_ready = rand_on ? rnd_ready : dir_ready;

   blit_combine_buf #(.ADDR_BITS(26), .WORD_BYTES(4), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .in_size(in_size), .in_last(in_last),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_byte_en(out_byte_en), .busy(busy)
   );

   blit_combine_buf #(.ADDR_BITS(26), .WORD_BYTES(8), .DEPTH(4)) dut8 (
      .clock(clock), .reset(reset), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
      .in_addr(w8_in_addr), .in_data(w8_in_data), .in_size(w8_in_size), .in_last(w8_in_last),
      .flush(w8_flush), .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_addr(w8_out_addr),
      .out_data(w8_out_data), .out_byte_en(w8_out_byte_en), .busy(w8_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   always @(negedge clock) rnd_ready = ($urandom_range(0, 3) != 0);

   // Output monitors sample one unit before the rising edge that completes a handshake.
   always begin
      @(negedge clock);
      #4;
      if (out_valid) begin
         tests++;
         if (out_byte_en == 4'h0) begin
            fails++;
            $display("FAIL be_nonzero: got %h, expected non-zero", out_byte_en);
         end
      end
      if (out_valid && out_ready) got_q.push_back('{out_addr, out_data, out_byte_en});
   end

   always begin
      @(negedge clock);
      #4;
      if (w8_out_valid && w8_out_ready) begin
         got8_a.push_back(w8_out_addr);
         got8_d.push_back(w8_out_data);
         got8_b.push_back(w8_out_byte_en);
      end
   end

   function automatic logic [31:0] bmask32(input logic [3:0] b);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
      return m;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic void m_emit();
      word_t w;
      if (mp_m != 4'h0) begin
         w.a = mp_addr;
         w.b = mp_m;
         w.d = {mp_b[3], mp_b[2], mp_b[1], mp_b[0]};
         exp_q.push_back(w);
      end
      mp_m = 4'h0;
      mp_f = 1'b0;
   endfunction

   // Reference: a beat closes the open word if it targets another word, the word is
   // complete, or the previous beat asked for a flush; then its bytes are merged in.
   function automatic void m_beat(input logic [25:0] a, input logic [31:0] d, input logic [1:0] s, input logic l);
      int n, off;
      logic [25:0] wa;
      n   = (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 1;
      off = int'(a % 4);
      off = off - off % n;
      wa  = a - a % 4;
      if (mp_m != 4'h0 && (wa != mp_addr || mp_m == 4'hF || mp_f)) m_emit();
      for (int i = 0; i < n; i++) begin
         mp_b[off + i] = d[8*i +: 8];
         mp_m[off + i] = 1'b1;
      end
      mp_addr = wa;
      mp_f    = l;
   endfunction

   // Called at a falling edge; returns at the falling edge after the beat is accepted.
   task automatic beat(input logic [25:0] a, input logic [31:0] d, input logic [1:0] s, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      in_size  = s;
      in_last  = l;
      #4;
      while (!in_ready && n < 200) begin
         @(negedge clock);
         #4;
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL beat_accept: got in_ready=0 for 200 cycles, expected acceptance at %h", a);
      end else if (model_on) m_beat(a, d, s, l);
      @(negedge clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_word(input string nm, input logic [25:0] a, input logic [31:0] d, input logic [3:0] b);
      word_t w;
      int n = 0;
      while (got_q.size() == 0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (got_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got no word, expected addr %h", nm, a);
      end else begin
         w = got_q.pop_front();
         chk({nm, "_addr"}, 64'(w.a), 64'(a));
         chk({nm, "_be"}, 64'(w.b), 64'(b));
         chk({nm, "_data"}, 64'(w.d & bmask32(b)), 64'(d & bmask32(b)));
      end
   endtask

   vec_t tbl [8];
   int   acc;

   initial begin
      tbl[0] = '{26'h10,      32'h000000A5, 2'd0, 26'h10,      32'h000000A5, 4'b0001};
      tbl[1] = '{26'h13,      32'h0000003C, 2'd0, 26'h10,      32'h3C000000, 4'b1000};
      tbl[2] = '{26'h21,      32'h0000BEEF, 2'd1, 26'h20,      32'h0000BEEF, 4'b0011};
      tbl[3] = '{26'h22,      32'h00001234, 2'd1, 26'h20,      32'h12340000, 4'b1100};
      tbl[4] = '{26'h37,      32'hDEADBEEF, 2'd2, 26'h34,      32'hDEADBEEF, 4'b1111};
      tbl[5] = '{26'h42,      32'hFFFFFF77, 2'd3, 26'h40,      32'h00770000, 4'b0100};
      tbl[6] = '{26'h4F,      32'h0000CAFE, 2'd1, 26'h4C,      32'hCAFE0000, 4'b1100};
      tbl[7] = '{26'h3FFFFFD, 32'h0000005A, 2'd0, 26'h3FFFFFC, 32'h00005A00, 4'b0010};

      reset = 1'b1;
      {in_valid, in_last, flush, in_addr, in_data, in_size} = '0;
      {w8_in_valid, w8_in_last, w8_flush, w8_in_addr, w8_in_data, w8_in_size} = '0;
      w8_out_ready = 1'b1;
      dir_ready    = 1'b1;
      rand_on      = 1'b0;
      model_on     = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_be", 64'(out_byte_en), 64'd0);
      chk("rst8_out_valid", 64'(w8_out_valid), 64'd0);
      chk("rst8_in_ready", 64'(w8_in_ready), 64'd1);
      @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         beat(tbl[i].a, tbl[i].d, tbl[i].s, 1'b1);
         expect_word($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ed, tbl[i].eb);
      end

      for (int i = 0; i < 4; i++) beat(26'h100 + 26'(i), 32'(8'h11 * (i + 1)), 2'd0, 1'b0);
      beat(26'h104, 32'h55, 2'd0, 1'b1);
      expect_word("bytes4_w0", 26'h100, 32'h44332211, 4'b1111);
      expect_word("bytes4_w1", 26'h104, 32'h00000055, 4'b0001);

      beat(26'h202, 32'h0000BBAA, 2'd1, 1'b0);
      beat(26'h200, 32'h000000CC, 2'd0, 1'b1);
      expect_word("half_byte", 26'h200, 32'hBBAA00CC, 4'b1101);

      beat(26'h300, 32'h11111111, 2'd2, 1'b0);
      beat(26'h300, 32'h22222222, 2'd2, 1'b1);
      expect_word("same_w0", 26'h300, 32'h11111111, 4'b1111);
      expect_word("same_w1", 26'h300, 32'h22222222, 4'b1111);

      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      repeat (5) @(negedge clock);
      chk("empty_flush_words", 64'(got_q.size()), 64'd0);
      chk("empty_flush_busy", 64'(busy), 64'd0);

      beat(26'h700, 32'h99, 2'd0, 1'b0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      expect_word("flush_pend", 26'h700, 32'h99, 4'b0001);

      // Back-pressure: DEPTH words fill the FIFO, one more sits in pending.
      dir_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         in_addr  = 26'h500 + 26'(4 * acc);
         in_data  = 32'hA0000000 + 32'(acc);
         in_size  = 2'd2;
         #4;
         if (in_ready) acc++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      #4;
      chk("bp_accepted", 64'(acc), 64'd5);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clock);
      dir_ready = 1'b1;
      for (int i = 0; i < 5; i++)
         expect_word($sformatf("bp_w%0d", i), 26'h500 + 26'(4 * i), 32'hA0000000 + 32'(i), 4'b1111);

      dir_ready = 1'b0;
      beat(26'h600, 32'h66666666, 2'd2, 1'b0);
      beat(26'h604, 32'h77777777, 2'd2, 1'b0);
      beat(26'h608, 32'h00001234, 2'd1, 1'b0);
      #1;
      chk("prerst_busy", 64'(busy), 64'd1);
      chk("prerst_out_valid", 64'(out_valid), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("postrst_out_valid", 64'(out_valid), 64'd0);
      chk("postrst_busy", 64'(busy), 64'd0);
      chk("postrst_in_ready", 64'(in_ready), 64'd1);
      chk("postrst_be", 64'(out_byte_en), 64'd0);
      @(negedge clock);
      dir_ready = 1'b1;
      repeat (10) @(negedge clock);
      chk("postrst_stale", 64'(got_q.size()), 64'd0);

      for (int i = 0; i < 8; i++) begin
         w8_in_valid = 1'b1;
         w8_in_addr  = 26'h400 + 26'(i);
         w8_in_data  = 32'h10 + 32'(i);
         w8_in_size  = 2'd0;
         w8_in_last  = (i == 7);
         #4;
         if (!w8_in_ready) begin
            tests++;
            fails++;
            $display("FAIL w8_ready: got 0 on beat %0d, expected 1", i);
         end
         @(negedge clock);
      end
      w8_in_valid = 1'b0;
      w8_in_last  = 1'b0;
      for (int n = 0; n < 60 && got8_a.size() == 0; n++) @(negedge clock);
      if (got8_a.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL w8_word: got no word, expected addr 400");
      end else begin
         chk("w8_addr", 64'(got8_a.pop_front()), 64'h400);
         chk("w8_be", 64'(got8_b.pop_front()), 64'hFF);
         chk("w8_data", got8_d.pop_front(), 64'h1716151413121110);
      end

      got_q.delete();
      mp_m     = 4'h0;
      mp_f     = 1'b0;
      model_on = 1'b1;
      rand_on  = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clock);
         else beat(26'h800 + 26'($urandom_range(0, 11)), $urandom, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0);
      end
      rand_on = 1'b0;
      flush   = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      for (int n = 0; n < 200 && busy; n++) @(negedge clock);
      chk("rand_drained", 64'(busy), 64'd0);
      repeat (2) @(negedge clock);
      m_emit();
      chk("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("rand%0d_addr", i), 64'(got_q[i].a), 64'(exp_q[i].a));
         chk($sformatf("rand%0d_be", i), 64'(got_q[i].b), 64'(exp_q[i].b));
         chk($sformatf("rand%0d_data", i), 64'(got_q[i].d & bmask32(exp_q[i].b)),
             64'(exp_q[i].d & bmask32(exp_q[i].b)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
